// File: rtl/alarm_clock_ctrl.sv
// rtl/alarm_clock_ctrl.sv - alarm clock mode FSM, timekeeper and alarm
//
// Purpose: owns clock/alarm HH:MM registers, the adjust-mode FSM and the
// alarm ring; drives the BCD digit word for the display path.
// Optional feature macro: ALARM_SNOOZE_EN (btn_d while ringing snoozes).
//
// Ports:
//   clk          in   system clock
//   reset        in   synchronous, active-high reset
//   tick_1hz     in   one-cycle pulse at 1 Hz
//   btn_c/r/l/u/d in  one-cycle debounced button pulses (priority c>r>l>u>d)
//   disp_digits  out  BCD {hours_tens, hours, minutes_tens, minutes}
//   mode         out  current FSM state encoding
//   edit_mask    out  digits being edited (1 = blink)
//   alarm_ring   out  alarm active
module alarm_clock_ctrl #(
    parameter int TICKS_PER_MIN = 60,
    parameter int RING_TICKS    = 60,
    parameter int SNOOZE_MIN    = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick_1hz,
    input  logic        btn_c,
    input  logic        btn_r,
    input  logic        btn_l,
    input  logic        btn_u,
    input  logic        btn_d,
    output logic [15:0] disp_digits,
    output logic [2:0]  mode,
    output logic [3:0]  edit_mask,
    output logic        alarm_ring
);

    localparam int SEC_W  = (TICKS_PER_MIN > 1) ? $clog2(TICKS_PER_MIN) : 1;
    localparam int RING_W = (RING_TICKS > 1) ? $clog2(RING_TICKS) : 1;

    typedef enum logic [2:0] {
        CLOCK       = 3'b000,
        ADJ_MIN_CLK = 3'b010,
        ADJ_HR_CLK  = 3'b011,
        ADJ_MIN_ALM = 3'b100,
        ADJ_HR_ALM  = 3'b101
    } state_t;

    typedef enum logic [2:0] {
        BTN_NONE, BTN_C, BTN_R, BTN_L, BTN_U, BTN_D
    } btn_t;

    state_t              state_q, state_d;
    logic [4:0]          clk_hr_q, clk_hr_d;
    logic [5:0]          clk_min_q, clk_min_d;
    logic [4:0]          alm_hr_q, alm_hr_d;
    logic [5:0]          alm_min_q, alm_min_d;
    logic [SEC_W-1:0]    sec_cnt_q, sec_cnt_d;
    logic                ring_q, ring_d;
    logic [RING_W-1:0]   ring_cnt_q, ring_cnt_d;
`ifdef ALARM_SNOOZE_EN
    localparam int SNZ_W = $clog2(SNOOZE_MIN + 1);
    logic [SNZ_W-1:0]    snooze_cnt_q, snooze_cnt_d;
`endif

    btn_t btn_sel;
    logic btn_any;
    logic time_run;
    logic rollover;
    logic trigger;
    logic snooze_fire;
    logic consume;
    logic up;

    function automatic logic [5:0] step_min(input logic [5:0] v, input logic inc);
        if (inc) return (v == 6'd59) ? 6'd0 : v + 6'd1;
        return (v == 6'd0) ? 6'd59 : v - 6'd1;
    endfunction

    function automatic logic [4:0] step_hr(input logic [4:0] v, input logic inc);
        if (inc) return (v == 5'd23) ? 5'd0 : v + 5'd1;
        return (v == 5'd0) ? 5'd23 : v - 5'd1;
    endfunction

    // Ones digit is taken mod 16: v - 10*tens is below 10, so the low nibble is exact.
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [3:0] ones;
        if (v >= 6'd50)      tens = 4'd5;
        else if (v >= 6'd40) tens = 4'd4;
        else if (v >= 6'd30) tens = 4'd3;
        else if (v >= 6'd20) tens = 4'd2;
        else if (v >= 6'd10) tens = 4'd1;
        else                 tens = 4'd0;
        ones = v[3:0] - tens * 4'd10;
        return {tens, ones};
    endfunction

    always_comb begin
        btn_sel = BTN_NONE;
        if (btn_c)      btn_sel = BTN_C;
        else if (btn_r) btn_sel = BTN_R;
        else if (btn_l) btn_sel = BTN_L;
        else if (btn_u) btn_sel = BTN_U;
        else if (btn_d) btn_sel = BTN_D;
    end

    assign btn_any  = btn_c | btn_r | btn_l | btn_u | btn_d;
    assign time_run = (state_q == CLOCK) || (state_q == ADJ_MIN_ALM) || (state_q == ADJ_HR_ALM);
    assign up       = (btn_sel == BTN_U);

    always_comb begin
        state_d     = state_q;
        clk_hr_d    = clk_hr_q;
        clk_min_d   = clk_min_q;
        alm_hr_d    = alm_hr_q;
        alm_min_d   = alm_min_q;
        sec_cnt_d   = sec_cnt_q;
        ring_d      = ring_q;
        ring_cnt_d  = ring_cnt_q;
        rollover    = 1'b0;
        snooze_fire = 1'b0;
`ifdef ALARM_SNOOZE_EN
        snooze_cnt_d = snooze_cnt_q;
`endif

        if (tick_1hz && time_run) begin
            if (sec_cnt_q == SEC_W'(TICKS_PER_MIN - 1)) begin
                sec_cnt_d = '0;
                rollover  = 1'b1;
                if (clk_min_q == 6'd59) begin
                    clk_min_d = 6'd0;
                    clk_hr_d  = (clk_hr_q == 5'd23) ? 5'd0 : clk_hr_q + 5'd1;
                end else begin
                    clk_min_d = clk_min_q + 6'd1;
                end
            end else begin
                sec_cnt_d = sec_cnt_q + SEC_W'(1);
            end
        end

        // Compare the post-rollover time against the current alarm register.
        trigger = rollover && (clk_hr_d == alm_hr_q) && (clk_min_d == alm_min_q);

`ifdef ALARM_SNOOZE_EN
        if (rollover && (snooze_cnt_q != '0)) begin
            snooze_cnt_d = snooze_cnt_q - SNZ_W'(1);
            snooze_fire  = (snooze_cnt_q == SNZ_W'(1));
        end
`endif

        // A button is swallowed when it silences the ring or collides with a new ring.
        consume = ring_q | trigger | snooze_fire;

        if (trigger || snooze_fire) begin
            ring_d     = 1'b1;
            ring_cnt_d = '0;
        end else if (ring_q && btn_any) begin
            ring_d     = 1'b0;
            ring_cnt_d = '0;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt_d = (btn_sel == BTN_D) ? SNZ_W'(SNOOZE_MIN) : '0;
`endif
        end else if (ring_q && tick_1hz) begin
            if (ring_cnt_q == RING_W'(RING_TICKS - 1)) begin
                ring_d     = 1'b0;
                ring_cnt_d = '0;
            end else begin
                ring_cnt_d = ring_cnt_q + RING_W'(1);
            end
        end

        case (state_q)
            CLOCK: begin
                if (!consume && (btn_sel == BTN_C)) state_d = ADJ_HR_CLK;
            end
            ADJ_HR_CLK, ADJ_MIN_CLK, ADJ_HR_ALM, ADJ_MIN_ALM: begin
                if (!consume) begin
                    case (btn_sel)
                        BTN_C: state_d = CLOCK;
                        BTN_R: begin
                            case (state_q)
                                ADJ_HR_CLK:  state_d = ADJ_MIN_CLK;
                                ADJ_MIN_CLK: state_d = ADJ_HR_ALM;
                                ADJ_HR_ALM:  state_d = ADJ_MIN_ALM;
                                default:     state_d = ADJ_HR_CLK;
                            endcase
                        end
                        BTN_L: begin
                            case (state_q)
                                ADJ_HR_CLK:  state_d = ADJ_MIN_ALM;
                                ADJ_MIN_ALM: state_d = ADJ_HR_ALM;
                                ADJ_HR_ALM:  state_d = ADJ_MIN_CLK;
                                default:     state_d = ADJ_HR_CLK;
                            endcase
                        end
                        BTN_U, BTN_D: begin
                            case (state_q)
                                ADJ_HR_CLK: begin
                                    clk_hr_d  = step_hr(clk_hr_q, up);
                                    sec_cnt_d = '0;
                                end
                                ADJ_MIN_CLK: begin
                                    clk_min_d = step_min(clk_min_q, up);
                                    sec_cnt_d = '0;
                                end
                                ADJ_HR_ALM:  alm_hr_d  = step_hr(alm_hr_q, up);
                                default:     alm_min_d = step_min(alm_min_q, up);
                            endcase
                        end
                        default: ;
                    endcase
                end
            end
            default: state_d = CLOCK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= CLOCK;
            clk_hr_q   <= '0;
            clk_min_q  <= '0;
            alm_hr_q   <= '0;
            alm_min_q  <= '0;
            sec_cnt_q  <= '0;
            ring_q     <= 1'b0;
            ring_cnt_q <= '0;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            clk_hr_q   <= clk_hr_d;
            clk_min_q  <= clk_min_d;
            alm_hr_q   <= alm_hr_d;
            alm_min_q  <= alm_min_d;
            sec_cnt_q  <= sec_cnt_d;
            ring_q     <= ring_d;
            ring_cnt_q <= ring_cnt_d;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt_q <= snooze_cnt_d;
`endif
        end
    end

    assign mode       = state_q;
    assign alarm_ring = ring_q;

    always_comb begin
        edit_mask = 4'b0000;
        case (state_q)
            ADJ_HR_CLK, ADJ_HR_ALM:   edit_mask = 4'b1100;
            ADJ_MIN_CLK, ADJ_MIN_ALM: edit_mask = 4'b0011;
            default:                  edit_mask = 4'b0000;
        endcase
    end

    always_comb begin
        if ((state_q == ADJ_MIN_ALM) || (state_q == ADJ_HR_ALM))
            disp_digits = {to_bcd({1'b0, alm_hr_q}), to_bcd(alm_min_q)};
        else
            disp_digits = {to_bcd({1'b0, clk_hr_q}), to_bcd(clk_min_q)};
    end

endmodule
